idel_train_block: RTL and testbench

- Next-generation PHY read-data capture block for the Versal-style path, where the RX FIFO runs at system clock speed.
- Per line, aligns deserialised data using a parametrised bit-granular coarse delay pipe.
- Adds a hardware read-training engine that sweeps each line's delay against a known repeating pattern, then locks the smallest matching delay.
- Sits between the byte-group RX FIFOs and the memory controller read path. Software can override trained delays through parameter registers.

---
 rtl/aimc_lib.sv | 20 ++
 rtl/idel_train_block_if.sv | 24 ++
 rtl/idel_line_pipe.sv | 53 +++++
 rtl/idel_train_block.sv | 176 +++++++++++++++++
 tb/tb_idel_train_block.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aimc_lib.sv
// Shared definitions for the read-data capture path: training FSM states,
// default geometry and the delay-width helper.
package aimc_lib;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        UPDATE,
        DONE
    } train_state_t;

    localparam int IDEL_SER     = 8;
    localparam int IDEL_MAX_DEL = 16;

    function automatic int idel_del_w(input int max_del);
        return $clog2(max_del);
    endfunction

endpackage

// File: rtl/idel_train_block_if.sv
// Beat bus between the byte-group RX FIFOs (master) and the capture block (slave).
interface idel_train_block_if #(
    parameter int LINES = 16,
    parameter int SER   = 8
);
    logic                   rx_valid;
    logic [LINES*SER-1:0]   rx_q;
    logic [LINES*SER-1:0]   phy_dout;
    logic                   phy_dout_vld;

    modport master (
        output rx_valid,
        output rx_q,
        input  phy_dout,
        input  phy_dout_vld
    );

    modport slave (
        input  rx_valid,
        input  rx_q,
        output phy_dout,
        output phy_dout_vld
    );
endinterface

// File: rtl/idel_line_pipe.sv
// One DQ line: beat history, two bit-granular delay taps (data path and
// training comparison path) and their output registers.
module idel_line_pipe #(
    parameter int SER     = 8,
    parameter int MAX_DEL = 16,
    parameter int DW      = 4
) (
    input  logic            clk_div,
    input  logic            rst_div,
    input  logic            rx_valid,
    input  logic [SER-1:0]  rx_q,
    input  logic [DW-1:0]   eff_del,
    input  logic [DW-1:0]   cand_del,
    output logic [SER-1:0]  dout,
    output logic [SER-1:0]  cmp_dout
);
    localparam int PIPE = MAX_DEL / SER + 1;
    localparam int HW   = (PIPE - 1) * SER;

    logic [HW-1:0]         hist_q, hist_d;
    logic [SER-1:0]        dout_q, dout_d;
    logic [SER-1:0]        cmp_q, cmp_d;
    logic [PIPE*SER-1:0]   window;

    // Oldest bit sits at window[0]; delay d selects the SER bits starting d before the current beat.
    assign window = {rx_q, hist_q};

    always_comb begin
        hist_d = hist_q;
        dout_d = dout_q;
        cmp_d  = cmp_q;
        if (rx_valid) begin
            hist_d = window[PIPE*SER-1:SER];
            dout_d = SER'(window >> (HW - 32'(eff_del)));
            cmp_d  = SER'(window >> (HW - 32'(cand_del)));
        end
    end

    always_ff @(posedge clk_div) begin
        if (rst_div) begin
            hist_q <= '0;
            dout_q <= '0;
            cmp_q  <= '0;
        end else begin
            hist_q <= hist_d;
            dout_q <= dout_d;
            cmp_q  <= cmp_d;
        end
    end

    assign dout     = dout_q;
    assign cmp_dout = cmp_q;
endmodule

// File: rtl/idel_train_block.sv
// Read-data capture with per-line coarse delay and a hardware read-training
// engine that locks the smallest delay reproducing train_pattern.
module idel_train_block
    import aimc_lib::*;
#(
    parameter int LINES    = 16,
    parameter int SER      = IDEL_SER,
    parameter int MAX_DEL  = IDEL_MAX_DEL,
    parameter int MATCH_N  = 8,
    parameter int SETTLE_N = 4,
    localparam int DW      = idel_del_w(MAX_DEL)
) (
    input  logic                  clk_div,
    input  logic                  rst_div,
    idel_train_block_if.slave     dq,
    input  logic                  param_ovrd,
    input  logic [LINES*DW-1:0]   param_io_in_del,
    input  logic                  train_start,
    input  logic [SER-1:0]        train_pattern,
    output logic                  train_busy,
    output logic                  train_done,
    output logic                  train_fail,
    output logic [LINES-1:0]      line_fail,
    output logic [LINES*DW-1:0]   trained_del
);
    localparam int MW = $clog2(MATCH_N + 1);
    localparam int CW = $clog2(MATCH_N + SETTLE_N + 2);

    train_state_t               state_q, state_d;
    logic [CW-1:0]              beat_cnt_q, beat_cnt_d;
    logic [LINES-1:0][DW-1:0]   cand_del_q, cand_del_d;
    logic [LINES-1:0][DW-1:0]   trained_del_q, trained_del_d;
    logic [LINES-1:0][DW-1:0]   eff_del;
    logic [LINES-1:0][MW-1:0]   match_cnt_q, match_cnt_d;
    logic [LINES-1:0]           lock_q, lock_d;
    logic [LINES-1:0]           line_fail_q, line_fail_d;
    logic [LINES-1:0]           seen_mm_q, seen_mm_d;
    logic                       busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic                       vld_q, vld_d;
    logic [LINES-1:0][SER-1:0]  dout_w, cmp_w;

    always_comb begin
        for (int l = 0; l < LINES; l++) begin
            eff_del[l] = param_ovrd ? param_io_in_del[l*DW +: DW] : cand_del_q[l];
        end
    end

    for (genvar l = 0; l < LINES; l++) begin : g_line
        idel_line_pipe #(.SER(SER), .MAX_DEL(MAX_DEL), .DW(DW)) u_pipe (
            .clk_div  (clk_div),
            .rst_div  (rst_div),
            .rx_valid (dq.rx_valid),
            .rx_q     (dq.rx_q[l*SER +: SER]),
            .eff_del  (eff_del[l]),
            .cand_del (cand_del_q[l]),
            .dout     (dout_w[l]),
            .cmp_dout (cmp_w[l])
        );
    end

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        cand_del_d    = cand_del_q;
        trained_del_d = trained_del_q;
        match_cnt_d   = match_cnt_q;
        lock_d        = lock_q;
        line_fail_d   = line_fail_q;
        seen_mm_d     = seen_mm_q;
        busy_d        = busy_q;
        done_d        = done_q;
        fail_d        = fail_q;
        vld_d         = dq.rx_valid;
        unique case (state_q)
            IDLE: begin
                if (train_start) begin
                    cand_del_d  = '0;
                    lock_d      = '0;
                    line_fail_d = '0;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    busy_d      = 1'b1;
                    beat_cnt_d  = '0;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (vld_q) begin
                    if (beat_cnt_q == CW'(SETTLE_N - 1)) begin
                        beat_cnt_d  = '0;
                        match_cnt_d = '0;
                        seen_mm_d   = '0;
                        state_d     = CHECK;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                // A window ends early once every still-open line has either locked or shown a mismatch.
                if (vld_q) begin
                    for (int l = 0; l < LINES; l++) begin
                        if (!lock_q[l] && !line_fail_q[l]) begin
                            if (cmp_w[l] == train_pattern) begin
                                match_cnt_d[l] = match_cnt_q[l] + 1'b1;
                                if (match_cnt_q[l] == MW'(MATCH_N - 1)) lock_d[l] = 1'b1;
                            end else begin
                                match_cnt_d[l] = '0;
                                seen_mm_d[l]   = 1'b1;
                            end
                        end
                    end
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if ((&(lock_d | line_fail_q | seen_mm_d)) || (beat_cnt_q == CW'(MATCH_N)))
                        state_d = UPDATE;
                end
            end
            UPDATE: begin
                for (int l = 0; l < LINES; l++) begin
                    if (!lock_q[l] && !line_fail_q[l]) begin
                        if (cand_del_q[l] == DW'(MAX_DEL - 1)) line_fail_d[l] = 1'b1;
                        else cand_del_d[l] = cand_del_q[l] + 1'b1;
                    end
                end
                beat_cnt_d = '0;
                state_d    = (&(lock_q | line_fail_d)) ? DONE : SETTLE;
            end
            DONE: begin
                trained_del_d = cand_del_q;
                done_d        = 1'b1;
                fail_d        = |line_fail_q;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_div) begin
        if (rst_div) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            cand_del_q    <= '0;
            trained_del_q <= '0;
            match_cnt_q   <= '0;
            lock_q        <= '0;
            line_fail_q   <= '0;
            seen_mm_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
            vld_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            cand_del_q    <= cand_del_d;
            trained_del_q <= trained_del_d;
            match_cnt_q   <= match_cnt_d;
            lock_q        <= lock_d;
            line_fail_q   <= line_fail_d;
            seen_mm_q     <= seen_mm_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
            vld_q         <= vld_d;
        end
    end

    assign dq.phy_dout     = dout_w;
    assign dq.phy_dout_vld = vld_q;
    assign train_busy      = busy_q;
    assign train_done      = done_q;
    assign train_fail      = fail_q;
    assign line_fail       = line_fail_q;
    assign trained_del     = trained_del_q;
endmodule

// File: tb/tb_idel_train_block.sv
// Randomised directed bench for idel_train_block: bit-stream model for the
// delay path, rotation-search model for training results.
module tb_idel_train_block;
    import aimc_lib::*;

    localparam int LINES   = 16;
    localparam int SER     = 8;
    localparam int MAX_DEL = 16;
    localparam int DW      = 4;
    localparam int MAXB    = 512;

    logic                 clk_div = 1'b0;
    logic                 rst_div;
    logic                 param_ovrd;
    logic [LINES*DW-1:0]  param_io_in_del;
    logic                 train_start;
    logic [SER-1:0]       train_pattern;
    logic                 train_busy, train_done, train_fail;
    logic [LINES-1:0]     line_fail;
    logic [LINES*DW-1:0]  trained_del;

    int n_cmp = 0;
    int n_err = 0;

    bit                   sbits [LINES][MAXB*SER];
    int                   nbeat;
    logic [LINES*SER-1:0] exp_dout;

    always #5 clk_div = ~clk_div;

    idel_train_block_if #(.LINES(LINES), .SER(SER)) dq ();

    idel_train_block #(
        .LINES(LINES), .SER(SER), .MAX_DEL(MAX_DEL), .MATCH_N(8), .SETTLE_N(4)
    ) dut (
        .clk_div         (clk_div),
        .rst_div         (rst_div),
        .dq              (dq),
        .param_ovrd      (param_ovrd),
        .param_io_in_del (param_io_in_del),
        .train_start     (train_start),
        .train_pattern   (train_pattern),
        .train_busy      (train_busy),
        .train_done      (train_done),
        .train_fail      (train_fail),
        .line_fail       (line_fail),
        .trained_del     (trained_del)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no end, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_div);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output beat k at delay d is stream bits s[SER*k-d .. SER*k-d+SER-1]; bits before reset read as 0.
    function automatic logic [SER-1:0] modelTap(input int l, input int k, input int d);
        logic [SER-1:0] r;
        for (int j = 0; j < SER; j++) begin
            int idx;
            idx  = SER * k - d + j;
            r[j] = (idx < 0) ? 1'b0 : sbits[l][idx];
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic valid, input logic [LINES*SER-1:0] data, input bit chk_data);
        dq.rx_valid = valid;
        dq.rx_q     = data;
        if (valid) begin
            for (int l = 0; l < LINES; l++) begin
                for (int j = 0; j < SER; j++) sbits[l][SER*nbeat + j] = data[l*SER + j];
                exp_dout[l*SER +: SER] = modelTap(l, nbeat, int'(param_io_in_del[l*DW +: DW]));
            end
            nbeat++;
        end
        cycle();
        checkOutput("dout_vld", 128'(dq.phy_dout_vld), 128'(valid));
        if (chk_data) checkOutput("dout", 128'(dq.phy_dout), 128'(exp_dout));
    endtask

    // Stream advanced by a bits: beat bit j carries pattern bit (j+a) mod SER.
    function automatic logic [SER-1:0] advWord(input logic [SER-1:0] p, input int a);
        logic [SER-1:0] r;
        for (int j = 0; j < SER; j++) r[j] = p[(j + a) % SER];
        return r;
    endfunction

    // A line repeating word w, delayed by d, shows w rotated; lock is the smallest d that yields the pattern.
    task automatic trainModel(input logic [SER-1:0] pat, input logic [LINES*SER-1:0] words,
                              output logic [LINES*DW-1:0] del, output logic [LINES-1:0] fail);
        for (int l = 0; l < LINES; l++) begin
            logic [SER-1:0] w, r;
            bit found;
            int dsel;
            w = words[l*SER +: SER];
            found = 0;
            dsel = MAX_DEL - 1;
            for (int d = 0; d < MAX_DEL; d++) begin
                for (int j = 0; j < SER; j++) r[j] = w[(((j - d) % SER) + SER) % SER];
                if (!found && r == pat) begin
                    found = 1;
                    dsel  = d;
                end
            end
            del[l*DW +: DW] = DW'(dsel);
            fail[l]         = !found;
        end
    endtask

    task automatic runTrain(input string tag, input logic [SER-1:0] pat,
                            input logic [LINES*SER-1:0] words, input bit stall, input bit abort);
        logic [LINES*DW-1:0] exp_del;
        logic [LINES-1:0]    exp_fail;
        int budget;
        trainModel(pat, words, exp_del, exp_fail);
        train_pattern   = pat;
        dq.rx_q         = words;
        param_ovrd      = 1'($urandom_range(0, 1));
        param_io_in_del = 64'({$urandom, $urandom});
        dq.rx_valid     = 1'b1;
        cycle();
        cycle();
        train_start = 1'b1;
        cycle();
        train_start = 1'b0;
        checkOutput({tag, " busy_set"}, 128'(train_busy), 128'(1));
        checkOutput({tag, " done_clr"}, 128'(train_done), 128'(0));
        if (stall || abort) begin
            budget = 0;
            while (dut.state_q != (abort ? UPDATE : CHECK) && budget < 2000) begin
                dq.rx_valid = ($urandom_range(0, 3) != 0);
                cycle();
                budget++;
            end
            checkOutput({tag, " reach_state"}, 128'(budget < 2000), 128'(1));
        end
        if (abort) begin
            rst_div = 1'b1;
            cycle();
            rst_div = 1'b0;
            checkOutput({tag, " rst_busy"}, 128'(train_busy), 128'(0));
            checkOutput({tag, " rst_done"}, 128'(train_done), 128'(0));
            checkOutput({tag, " rst_fail"}, 128'(train_fail), 128'(0));
            checkOutput({tag, " rst_line_fail"}, 128'(line_fail), 128'(0));
            checkOutput({tag, " rst_trained_del"}, 128'(trained_del), 128'(0));
            checkOutput({tag, " rst_dout"}, 128'(dq.phy_dout), 128'(0));
            return;
        end
        if (stall) begin
            dq.rx_valid = 1'b0;
            for (int i = 0; i < 20; i++) begin
                train_start = (i == 10);
                cycle();
                checkOutput({tag, " stall_busy"}, 128'(train_busy), 128'(1));
            end
            train_start = 1'b0;
            checkOutput({tag, " stall_done"}, 128'(train_done), 128'(0));
        end
        budget = 0;
        while (train_done !== 1'b1 && budget < 3000) begin
            dq.rx_valid = ($urandom_range(0, 3) != 0);
            cycle();
            budget++;
        end
        checkOutput({tag, " done"}, 128'(train_done), 128'(1));
        checkOutput({tag, " busy_clr"}, 128'(train_busy), 128'(0));
        checkOutput({tag, " trained_del"}, 128'(trained_del), 128'(exp_del));
        checkOutput({tag, " line_fail"}, 128'(line_fail), 128'(exp_fail));
        checkOutput({tag, " train_fail"}, 128'(train_fail), 128'(|exp_fail));
    endtask

    initial begin
        logic [LINES*SER-1:0] data;
        logic [LINES*SER-1:0] words;
        logic [SER-1:0]       pat;
        bit                   first;
        logic                 v;

        rst_div         = 1'b1;
        train_start     = 1'b0;
        param_ovrd      = 1'b0;
        param_io_in_del = '0;
        train_pattern   = '0;
        dq.rx_valid     = 1'b0;
        dq.rx_q         = '0;
        exp_dout        = '0;
        repeat (2) cycle();
        rst_div = 1'b0;
        checkOutput("rst_dout", 128'(dq.phy_dout), 128'(0));
        checkOutput("rst_vld", 128'(dq.phy_dout_vld), 128'(0));
        checkOutput("rst_busy", 128'(train_busy), 128'(0));
        checkOutput("rst_done", 128'(train_done), 128'(0));
        checkOutput("rst_fail", 128'(train_fail), 128'(0));
        checkOutput("rst_line_fail", 128'(line_fail), 128'(0));
        checkOutput("rst_trained_del", 128'(trained_del), 128'(0));

        nbeat      = 0;
        param_ovrd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data       = rnd128();
            data[7:0]  = 8'hA5;
            applyStimulus(1'b1, data, 1'b1);
            checkOutput("bypass_a5", 128'(dq.phy_dout[7:0]), 128'(8'hA5));
        end

        param_io_in_del[3:0] = 4'd3;
        data      = rnd128();
        data[7:0] = 8'hFF;
        applyStimulus(1'b1, data, 1'b0);
        data      = rnd128();
        data[7:0] = 8'h00;
        applyStimulus(1'b1, data, 1'b1);
        checkOutput("del3_line0", 128'(dq.phy_dout[7:0]), 128'(8'h07));
        applyStimulus(1'b0, rnd128(), 1'b1);

        // The first valid beat after a delay change carries no glitch guarantee and is left unchecked.
        for (int seg = 0; seg < 3; seg++) begin
            for (int l = 0; l < LINES; l++) param_io_in_del[l*DW +: DW] = DW'($urandom_range(0, MAX_DEL - 1));
            first = 1;
            for (int i = 0; i < 40; i++) begin
                v = first || ($urandom_range(0, 3) != 0);
                applyStimulus(v, rnd128(), !first);
                if (v) first = 0;
            end
        end

        pat = 8'hB4;
        for (int l = 0; l < LINES; l++) words[l*SER +: SER] = pat;
        words[0*SER +: SER] = advWord(pat, 3);
        words[5*SER +: SER] = advWord(pat, 10);
        runTrain("train_dir", pat, words, 1'b0, 1'b0);
        checkOutput("dir_line0_del", 128'(trained_del[0*DW +: DW]), 128'(4'd3));
        // 0xB4 repeats every beat, so a 10-bit advance already aligns at delay 10-8=2.
        checkOutput("dir_line5_del", 128'(trained_del[5*DW +: DW]), 128'(4'd2));

        runTrain("train_stall", pat, words, 1'b1, 1'b0);

        for (int l = 0; l < LINES; l++) words[l*SER +: SER] = pat;
        words[2*SER +: SER] = 8'h00;
        runTrain("train_fail", pat, words, 1'b0, 1'b0);
        checkOutput("fail_line2_flag", 128'(line_fail[2]), 128'(1));
        checkOutput("fail_line2_del", 128'(trained_del[2*DW +: DW]), 128'(4'd15));

        runTrain("train_abort", pat, words, 1'b0, 1'b1);
        runTrain("train_after_abort", pat, words, 1'b0, 1'b0);

        for (int it = 0; it < 4; it++) begin
            pat = 8'($urandom);
            for (int l = 0; l < LINES; l++) begin
                if ($urandom_range(0, 7) == 0) words[l*SER +: SER] = 8'($urandom);
                else words[l*SER +: SER] = advWord(pat, int'($urandom_range(0, 15)));
            end
            runTrain("train_rand", pat, words, 1'(it == 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
